// File: rtl/uart_report_pkg.sv
// Shared constants and types for the UART status-report transmitter.
package uart_report_pkg;

    localparam int MSG_LEN = 10;

    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_DOT   = 8'h2E;
    localparam logic [7:0] ASC_DASH  = 8'h2D;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_S     = 8'h53;
    localparam logic [7:0] ASC_C     = 8'h43;
    localparam logic [7:0] ASC_R     = 8'h52;
    localparam logic [7:0] ASC_P     = 8'h50;
    localparam logic [7:0] ASC_0     = 8'h30;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef struct packed {
        logic [6:0] dh;
        logic [6:0] dl;
        logic       dot;
        logic       en;
        logic       chg;
    } snap_t;

endpackage

// File: rtl/uart_report_tx_if.sv
// Byte link between the report generator and the UART transmitter.
interface uart_report_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;

    modport master (output tx_start, output tx_data, input tx_done);
    modport slave  (input tx_start, input tx_data, output tx_done);
endinterface

// File: rtl/uart_report_tx_bin2ascii2.sv
// Converts a 0..99 value to two ASCII digits; 100..127 renders as "--".
module bin2ascii2
    import uart_report_pkg::*;
(
    input  logic [6:0] val_i,
    output logic [7:0] tens_o,
    output logic [7:0] ones_o
);
    logic [6:0] tens;
    logic [6:0] ones;

    always_comb begin
        tens = val_i / 7'd10;
        ones = val_i - tens * 7'd10;
        if (val_i > 7'd99) begin
            tens_o = ASC_DASH;
            ones_o = ASC_DASH;
        end else begin
            tens_o = ASC_0 + {1'b0, tens};
            ones_o = ASC_0 + {1'b0, ones};
        end
    end
endmodule

// File: rtl/uart_report_tx.sv
// Snapshots display state and streams it as a 10-byte ASCII line, on request
// or on a periodic timer, paced by the UART tx_done pulse.
module uart_report_tx
    import uart_report_pkg::*;
#(
    parameter int unsigned AUTO_PERIOD = 100_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [6:0]       digit_h,
    input  logic [6:0]       digit_l,
    input  logic             dot,
    input  logic             enable,
    input  logic             change,
    uart_report_tx_if.master uart,
    output logic             busy,
    output logic             frame_done
);
    localparam logic [31:0] TIMER_LAST = (AUTO_PERIOD == 0) ? 32'd0 : 32'(AUTO_PERIOD - 1);

    logic [31:0] timer_q;
    logic        tick;
    logic [1:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        pending_q, pending_d;
    logic        trig_q, trig_d;
    logic        adv_q, adv_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  hold_q, hold_d;
    snap_t       snap_q, snap_d;
    logic [7:0]  h_tens, h_ones, l_tens, l_ones;
    logic [7:0]  byte_mux;

    assign tick = (AUTO_PERIOD != 0) && (timer_q == TIMER_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                timer_q <= '0;
        else if (tick)             timer_q <= '0;
        else if (AUTO_PERIOD != 0) timer_q <= timer_q + 32'd1;
    end

    bin2ascii2 u_h (.val_i(snap_q.dh), .tens_o(h_tens), .ones_o(h_ones));
    bin2ascii2 u_l (.val_i(snap_q.dl), .tens_o(l_tens), .ones_o(l_ones));

    always_comb begin
        byte_mux = 8'h00;
        case (idx_q)
            4'd0: byte_mux = snap_q.chg ? ASC_C : ASC_S;
            4'd1: byte_mux = snap_q.en  ? ASC_R : ASC_P;
            4'd2: byte_mux = ASC_SP;
            4'd3: byte_mux = h_tens;
            4'd4: byte_mux = h_ones;
            4'd5: byte_mux = snap_q.dot ? ASC_DOT : ASC_COLON;
            4'd6: byte_mux = l_tens;
            4'd7: byte_mux = l_ones;
            4'd8: byte_mux = ASC_CR;
            4'd9: byte_mux = ASC_LF;
            default: byte_mux = 8'h00;
        endcase
    end

    // Triggers are registered once, which gives the one-cycle request latency;
    // adv_q adds the matching cycle between a tx_done and the next start.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        adv_d        = adv_q;
        hold_d       = hold_q;
        snap_d       = snap_q;
        frame_done_d = 1'b0;
        trig_d       = req | tick;
        case (state_q)
            ST_IDLE: begin
                if (trig_q || pending_q) begin
                    snap_d    = '{dh: digit_h, dl: digit_l, dot: dot, en: enable, chg: change};
                    idx_d     = 4'd0;
                    pending_d = 1'b0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                hold_d  = byte_mux;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (adv_q) begin
                    adv_d   = 1'b0;
                    state_d = ST_START;
                end else if (uart.tx_done) begin
                    if (idx_q == 4'(MSG_LEN - 1)) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        adv_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && trig_q) pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            trig_q       <= 1'b0;
            adv_q        <= 1'b0;
            frame_done_q <= 1'b0;
            hold_q       <= 8'h00;
            snap_q       <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            trig_q       <= trig_d;
            adv_q        <= adv_d;
            frame_done_q <= frame_done_d;
            hold_q       <= hold_d;
            snap_q       <= snap_d;
        end
    end

    assign uart.tx_start = (state_q == ST_START);
    assign uart.tx_data  = (state_q == ST_START) ? byte_mux : hold_q;
    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_uart_report_tx.sv
// Directed bench for uart_report_tx: frame contents, timing, coalescing,
// snapshot, reset abort and the periodic timer.
module tb_uart_report_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rst_main_n, req;
    logic [6:0] dh, dl;
    logic       dot, en, chg;
    logic       busy, fdone, busy_a, fd_a, busy_z, fd_z;

    uart_report_tx_if m_if ();
    uart_report_tx_if a_if ();
    uart_report_tx_if z_if ();

    uart_report_tx dut (
        .clk(clk), .reset(rst_main_n), .req(req), .digit_h(dh), .digit_l(dl),
        .dot(dot), .enable(en), .change(chg), .uart(m_if), .busy(busy), .frame_done(fdone));

    uart_report_tx #(.AUTO_PERIOD(1000)) dut_a (
        .clk(clk), .reset(rst_n), .req(1'b0), .digit_h(dh), .digit_l(dl),
        .dot(dot), .enable(en), .change(chg), .uart(a_if), .busy(busy_a), .frame_done(fd_a));

    uart_report_tx #(.AUTO_PERIOD(0)) dut_z (
        .clk(clk), .reset(rst_n), .req(1'b0), .digit_h(dh), .digit_l(dl),
        .dot(dot), .enable(en), .change(chg), .uart(z_if), .busy(busy_z), .frame_done(fd_z));

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // UART models: tx_done 20 cycles after each tx_start.
    bit m_abort;
    initial begin m_if.tx_done = 1'b0; a_if.tx_done = 1'b0; z_if.tx_done = 1'b0; end
    always begin
        @(negedge clk);
        if (rst_main_n && m_if.tx_start) begin
            m_abort = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!rst_main_n) m_abort = 1'b1;
            end
            if (!m_abort && rst_main_n) begin
                m_if.tx_done = 1'b1; @(negedge clk); m_if.tx_done = 1'b0;
            end
        end
    end
    always begin
        @(negedge clk);
        if (a_if.tx_start) begin
            repeat (20) @(negedge clk);
            a_if.tx_done = 1'b1; @(negedge clk); a_if.tx_done = 1'b0;
        end
    end
    always begin
        @(negedge clk);
        if (z_if.tx_start) begin
            repeat (20) @(negedge clk);
            z_if.tx_done = 1'b1; @(negedge clk); z_if.tx_done = 1'b0;
        end
    end

    // Monitor, sampling 1 time unit after each rising edge.
    int          cyc = 0;
    logic [79:0] cap;
    int          nbytes, fd_cnt, starts, gap_err, fd_err, b2b_err, done_cyc, na, nz;
    int          a_t [4];
    logic        prev_start, prev_busy, prev_busy_a, prev_busy_z;
    initial begin
        cap = '0; nbytes = 0; fd_cnt = 0; starts = 0; gap_err = 0; fd_err = 0; b2b_err = 0;
        done_cyc = 0; na = 0; nz = 0; prev_start = 0; prev_busy = 0; prev_busy_a = 0; prev_busy_z = 0;
    end
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        if (m_if.tx_start) begin
            cap = {cap[71:0], m_if.tx_data};
            nbytes++;
            if (prev_start) b2b_err++;
            if (prev_busy && (cyc - done_cyc != 1)) gap_err++;
        end
        if (m_if.tx_done) done_cyc = cyc;
        if (fdone) begin
            fd_cnt++;
            if (!m_if.tx_done || busy) fd_err++;
        end
        if (busy && !prev_busy) starts++;
        if (busy_a && !prev_busy_a) begin
            if (na < 4) a_t[na] = cyc;
            na++;
        end
        if (busy_z && !prev_busy_z) nz++;
        prev_start  = m_if.tx_start;
        prev_busy   = busy;
        prev_busy_a = busy_a;
        prev_busy_z = busy_z;
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic pulse_req();
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
    endtask

    task automatic wait_fd(input int target, input string name);
        int t = 0;
        while (fd_cnt < target && t < 3000) begin step(1); t++; end
        if (fd_cnt < target) begin
            tot_cnt++;
            $display("FAIL %s: frame_done count %0d, expected %0d (timeout)", name, fd_cnt, target);
        end
    endtask

    task automatic wait_bytes(input int target, input string name);
        int t = 0;
        while (nbytes < target && t < 3000) begin step(1); t++; end
        if (nbytes < target) begin
            tot_cnt++;
            $display("FAIL %s: byte count %0d, expected %0d (timeout)", name, nbytes, target);
        end
    endtask

    typedef struct {
        logic [6:0]  dh, dl;
        logic        dot, en, chg;
        logic [79:0] exp;
    } vec_t;
    vec_t vecs [6];

    int f0, s0, rel_cyc;

    initial begin
        vecs[0] = '{7'd12,  7'd34,  1'b1, 1'b1, 1'b0, 80'h5352_2031_322E_3334_0D0A};
        vecs[1] = '{7'd5,   7'd120, 1'b0, 1'b0, 1'b1, 80'h4350_2030_353A_2D2D_0D0A};
        vecs[2] = '{7'd0,   7'd99,  1'b1, 1'b0, 1'b0, 80'h5350_2030_302E_3939_0D0A};
        vecs[3] = '{7'd100, 7'd7,   1'b0, 1'b1, 1'b1, 80'h4352_202D_2D3A_3037_0D0A};
        vecs[4] = '{7'd99,  7'd127, 1'b0, 1'b1, 1'b0, 80'h5352_2039_393A_2D2D_0D0A};
        vecs[5] = '{7'd60,  7'd9,   1'b1, 1'b0, 1'b1, 80'h4350_2036_302E_3039_0D0A};

        rst_n = 1'b0; rst_main_n = 1'b0; req = 1'b0;
        dh = 7'd12; dl = 7'd34; dot = 1'b1; en = 1'b1; chg = 1'b0;
        step(3);
        chk("rst_busy",       80'(busy),         80'(0));
        chk("rst_tx_start",   80'(m_if.tx_start), 80'(0));
        chk("rst_tx_data",    80'(m_if.tx_data),  80'(0));
        chk("rst_frame_done", 80'(fdone),        80'(0));
        @(negedge clk); rst_n = 1'b1; rst_main_n = 1'b1; rel_cyc = cyc;
        step(2);

        // Request latency and first byte
        cap = '0; nbytes = 0;
        @(negedge clk); req = 1'b1;
        @(posedge clk); #2;
        chk("lat_busy_k", 80'(busy), 80'(0));
        @(negedge clk); req = 1'b0;
        @(posedge clk); #2;
        chk("lat_busy_k1",  80'(busy),          80'(1));
        chk("lat_start_k1", 80'(m_if.tx_start), 80'(1));
        chk("lat_data_k1",  80'(m_if.tx_data),  80'h53);
        wait_fd(1, "lat_frame");
        chk("lat_frame_bytes", cap, vecs[0].exp);
        chk("lat_frame_nbytes", 80'(nbytes), 80'(10));
        step(3);

        for (int i = 0; i < 6; i++) begin
            dh = vecs[i].dh; dl = vecs[i].dl; dot = vecs[i].dot; en = vecs[i].en; chg = vecs[i].chg;
            cap = '0; nbytes = 0; f0 = fd_cnt;
            pulse_req();
            wait_fd(f0 + 1, $sformatf("vec%0d_wait", i));
            step(3);
            chk($sformatf("vec%0d_bytes", i),  cap,            vecs[i].exp);
            chk($sformatf("vec%0d_nbytes", i), 80'(nbytes),    80'(10));
            chk($sformatf("vec%0d_fdcnt", i),  80'(fd_cnt),    80'(f0 + 1));
        end

        // Coalescing: three requests during byte 4 give one extra frame
        f0 = fd_cnt; s0 = starts; nbytes = 0;
        pulse_req();
        wait_bytes(5, "coal_byte4");
        for (int i = 0; i < 3; i++) begin pulse_req(); step(1); end
        wait_fd(f0 + 1, "coal_first");
        chk("coal_idle_busy", 80'(busy), 80'(0));
        step(1);
        chk("coal_restart_busy",  80'(busy),          80'(1));
        chk("coal_restart_start", 80'(m_if.tx_start), 80'(1));
        wait_fd(f0 + 2, "coal_second");
        step(400);
        chk("coal_frames", 80'(starts - s0), 80'(2));

        // Snapshot stability
        dh = 7'd12; dl = 7'd34; dot = 1'b1; en = 1'b1; chg = 1'b0;
        cap = '0; nbytes = 0; f0 = fd_cnt;
        pulse_req();
        wait_bytes(1, "snap_byte0");
        dl = 7'd35;
        wait_fd(f0 + 1, "snap_first");
        chk("snap_first_dl", 80'(cap[31:16]), 80'h3334);
        cap = '0;
        pulse_req();
        wait_fd(f0 + 2, "snap_second");
        chk("snap_second_dl", 80'(cap[31:16]), 80'h3335);
        step(3);

        // Reset during WAIT of byte 6
        nbytes = 0;
        pulse_req();
        wait_bytes(7, "rst_byte6");
        step(5);
        @(negedge clk); rst_main_n = 1'b0; #1;
        chk("abort_busy",       80'(busy),          80'(0));
        chk("abort_tx_start",   80'(m_if.tx_start), 80'(0));
        chk("abort_tx_data",    80'(m_if.tx_data),  80'(0));
        chk("abort_frame_done", 80'(fdone),         80'(0));
        step(3);
        @(negedge clk); rst_main_n = 1'b1;
        s0 = starts;
        step(300);
        chk("abort_quiet", 80'(starts - s0), 80'(0));
        cap = '0; f0 = fd_cnt;
        pulse_req();
        wait_fd(f0 + 1, "abort_recover");
        chk("abort_recover_bytes", cap, 80'h5352_2031_322E_3335_0D0A);
        step(3);

        chk("no_b2b_start",      80'(b2b_err), 80'(0));
        chk("interbyte_gap",     80'(gap_err), 80'(0));
        chk("frame_done_timing", 80'(fd_err),  80'(0));

        // Periodic reports
        while (cyc < rel_cyc + 3600) step(1);
        chk("auto_count_ge3", 80'(na >= 3),              80'(1));
        chk("auto_first",     80'(a_t[0] - rel_cyc),     80'(1001));
        chk("auto_period1",   80'(a_t[1] - a_t[0]),      80'(1000));
        chk("auto_period2",   80'(a_t[2] - a_t[1]),      80'(1000));
        chk("auto_off",       80'(nz),                   80'(0));

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
